uart_rx_buffered: RTL and testbench

//  Serial receive front end feeding the core's input stream: 8N1 UART receiver plus byte FIFO.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_byte_fifo.sv | 69 ++++++
 rtl/uart_rx_buffered.sv | 146 ++++++++++++++
 tb/tb_uart_rx_buffered.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: frame width and
// the receive state machine encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO: rdata presents the oldest byte whenever empty is low.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [7:0]                 wdata,
    input  logic                       pop,
    output logic [7:0]                 rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; stale entries are
    // unreachable because rdata is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling, framing/overrun reporting and a
// show-ahead byte FIFO towards the core.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 86,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            rxd,
    input  logic                            rd_en,
    input  logic                            clr_err,
    output logic [7:0]                      rdata,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            ferr,
    output logic                            overrun
);

    localparam int            TW        = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_HALF_BIT - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rxd_meta_q, rxd_s_q;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 push_byte, frame_err;
    logic                 fifo_empty, fifo_full, pop_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_byte = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxd_s_q) begin
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                // A start bit that is no longer low at mid-bit was a glitch.
                if (timer_q == HALF_LAST) begin
                    if (rxd_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        timer_d   = '0;
                        bit_idx_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    timer_d = '0;
                    if (bit_idx_q == IDX_LAST) state_d = STOP;
                    else                       bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                if (timer_q == BIT_LAST) begin
                    state_d   = IDLE;
                    timer_d   = '0;
                    push_byte = rxd_s_q;
                    frame_err = !rxd_s_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop_ok = rd_en && !fifo_empty;
    assign ferr_d = frame_err;

    always_comb begin
        overrun_d = overrun_q;
        if (clr_err) overrun_d = 1'b0;
        if (push_byte && fifo_full && !pop_ok) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    // The stop-sample edge both completes the frame and writes the FIFO,
    // so the byte is visible to the core on that same edge.
    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_byte),
        .wdata (shift_d),
        .pop   (rd_en),
        .rdata (rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    assign empty   = fifo_empty;
    assign ferr    = ferr_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: vector table, corner-case
// sequences and a randomised run against a queue-based reference model.
module tb_uart_rx_buffered;

    localparam int CPHB       = 4;
    localparam int DEPTH      = 4;
    localparam int BIT_CLKS   = 2 * CPHB;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
    localparam int CW         = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstn, rxd, rd_en, clr_err;
    logic [7:0]    rdata;
    logic          empty, ferr, overrun;
    logic [CW-1:0] count;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   ferr_seen = 0;
    int   ferr_long = 0;
    logic ferr_prev = 1'b0;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLK_PER_HALF_BIT (CPHB),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .rxd     (rxd),
        .rd_en   (rd_en),
        .clr_err (clr_err),
        .rdata   (rdata),
        .empty   (empty),
        .count   (count),
        .ferr    (ferr),
        .overrun (overrun)
    );

    // Count ferr pulses and catch any pulse lasting more than one cycle.
    always @(negedge clk) begin
        if (ferr) begin
            ferr_seen++;
            if (ferr_prev) ferr_long++;
        end
        ferr_prev = ferr;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // Drives the first n_clks cycles of an 8N1 frame; rd_en is raised for
    // the one cycle ending at the receiver's stop-sample edge when asked.
    task automatic drive_frame(input logic [7:0] b, input bit stop_ok,
                               input bit pop_at_stop, input int n_clks);
        for (int c = 0; c < n_clks; c++) begin
            int bit_no;
            bit_no = c / BIT_CLKS;
            if (bit_no == 0)      rxd = 1'b0;
            else if (bit_no <= 8) rxd = b[bit_no-1];
            else                  rxd = stop_ok;
            rd_en = pop_at_stop && (c == FRAME_CLKS - 2);
            tick();
        end
        rd_en = 1'b0;
        rxd   = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pop_at_stop);
        drive_frame(b, stop_ok, pop_at_stop, FRAME_CLKS);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_count;
        logic [7:0] exp_head;
        bit         exp_ovr;
        int         exp_ferr;
        int         pops;
        int         gap;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] model_q[$];
    bit         model_ovr;
    int         model_ferr;
    int         base;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b0, 0, 1, 12};
        vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1'b0, 1, 0, 12};
        vecs[2] = '{8'h55, 1'b1, 1, 8'h55, 1'b0, 0, 1, 12};
        vecs[3] = '{8'h01, 1'b1, 1, 8'h01, 1'b0, 0, 0, 0};
        vecs[4] = '{8'h02, 1'b1, 2, 8'h01, 1'b0, 0, 0, 0};
        vecs[5] = '{8'h03, 1'b1, 3, 8'h01, 1'b0, 0, 0, 0};
        vecs[6] = '{8'h04, 1'b1, 4, 8'h01, 1'b0, 0, 0, 0};
        vecs[7] = '{8'h05, 1'b1, 4, 8'h01, 1'b1, 0, 0, 4};

        rstn = 1'b0; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        #12;
        check("reset count",   32'(count),   32'd0);
        check("reset empty",   32'(empty),   32'd1);
        check("reset rdata",   32'(rdata),   32'd0);
        check("reset ferr",    32'(ferr),    32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        tick();
        rstn = 1'b1;
        idle(5);

        // Table: single byte, framing error, recovery, fill to overrun.
        foreach (vecs[i]) begin
            base = ferr_seen;
            send_frame(vecs[i].data, vecs[i].stop_ok, 1'b0);
            check($sformatf("vec%0d count", i),   32'(count),   32'(vecs[i].exp_count));
            check($sformatf("vec%0d empty", i),   32'(empty),   32'(vecs[i].exp_count == 0));
            if (vecs[i].exp_count != 0)
                check($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vecs[i].exp_head));
            check($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d ferr", i),    32'(ferr_seen - base), 32'(vecs[i].exp_ferr));
            repeat (vecs[i].pops) pop();
            if (vecs[i].pops != 0) begin
                check($sformatf("vec%0d count after pop", i), 32'(count), 32'd0);
                check($sformatf("vec%0d empty after pop", i), 32'(empty), 32'd1);
            end
            idle(vecs[i].gap);
        end

        // Drain the overrun FIFO in order, pop while empty, then clear overrun.
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d rdata", i), 32'(rdata), 32'(i + 1));
            pop();
        end
        check("drained empty",     32'(empty),   32'd1);
        check("drained overrun",   32'(overrun), 32'd1);
        pop();
        check("pop-empty count",   32'(count),   32'd0);
        check("pop-empty empty",   32'(empty),   32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err overrun",   32'(overrun), 32'd0);

        // Short low glitch must be rejected at the half-bit sample.
        base = ferr_seen;
        rxd = 1'b0;
        repeat (3) tick();
        idle(20);
        check("glitch count", 32'(count),            32'd0);
        check("glitch ferr",  32'(ferr_seen - base), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("post-glitch rdata", 32'(rdata), 32'h5A);
        pop();
        idle(4);

        // Full FIFO with a pop on the stop-sample edge: no overrun, order kept.
        for (int i = 1; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
        check("full count",   32'(count),   32'd4);
        check("full overrun", 32'(overrun), 32'd0);
        send_frame(8'h05, 1'b1, 1'b1);
        check("simul overrun", 32'(overrun), 32'd0);
        check("simul count",   32'(count),   32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("simul%0d rdata", i), 32'(rdata), 32'(i + 2));
            pop();
        end
        check("simul drained", 32'(empty), 32'd1);
        idle(4);

        // Break: line low ~two frame times gives two framing errors, no data.
        base = ferr_seen;
        rxd = 1'b0;
        repeat (156) tick();
        idle(30);
        check("break ferr",  32'(ferr_seen - base), 32'd2);
        check("break count", 32'(count),            32'd0);

        // Reset in mid-DATA with two bytes queued.
        send_frame(8'hA1, 1'b1, 1'b0);
        send_frame(8'hA2, 1'b1, 1'b0);
        check("pre-reset count", 32'(count), 32'd2);
        drive_frame(8'h0F, 1'b1, 1'b0, 30);
        base = ferr_seen;
        rstn = 1'b0;
        #1;
        check("midreset empty",   32'(empty),   32'd1);
        check("midreset count",   32'(count),   32'd0);
        check("midreset rdata",   32'(rdata),   32'd0);
        tick();
        tick();
        rstn = 1'b1;
        idle(100);
        check("post-reset count", 32'(count),            32'd0);
        check("post-reset ferr",  32'(ferr_seen - base), 32'd0);
        send_frame(8'hFF, 1'b1, 1'b0);
        check("post-reset rdata", 32'(rdata), 32'hFF);
        check("post-reset cnt1",  32'(count), 32'd1);
        pop();
        idle(4);

        // Randomised frames against a queue-based model.
        model_q.delete();
        model_ovr  = 1'b0;
        model_ferr = 0;
        base       = ferr_seen;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit         ok;
            int         npop;
            b  = 8'($urandom);
            ok = ($urandom_range(7) != 0);
            send_frame(b, ok, 1'b0);
            if (!ok)                         model_ferr++;
            else if (model_q.size() < DEPTH) model_q.push_back(b);
            else                             model_ovr = 1'b1;
            check($sformatf("rnd%0d count", n),   32'(count),   32'(model_q.size()));
            check($sformatf("rnd%0d empty", n),   32'(empty),   32'(model_q.size() == 0));
            if (model_q.size() != 0)
                check($sformatf("rnd%0d rdata", n), 32'(rdata), 32'(model_q[0]));
            check($sformatf("rnd%0d overrun", n), 32'(overrun), 32'(model_ovr));
            check($sformatf("rnd%0d ferr", n),    32'(ferr_seen - base), 32'(model_ferr));
            npop = $urandom_range(2);
            for (int p = 0; p < npop; p++) begin
                if (model_q.size() != 0) begin
                    check($sformatf("rnd%0d pop%0d rdata", n, p), 32'(rdata), 32'(model_q[0]));
                    void'(model_q.pop_front());
                end
                pop();
            end
            if ($urandom_range(5) == 0) begin
                clr_err = 1'b1;
                tick();
                clr_err   = 1'b0;
                model_ovr = 1'b0;
            end
            idle(ok ? $urandom_range(3) : 12);
        end

        check("ferr single-cycle", 32'(ferr_long), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
